// File: rtl/scroll_reader.sv
// scroll_reader: fetches 16 rows from a frame buffer, one row at a time, and
// presents each row rotated left by a horizontal scroll offset for ROW_HOLD
// cycles. Every FRAMES_PER_STEP complete frames the offset steps by one.
// Optional macro SCROLL_DIR_EN adds a 'dir' input selecting the step
// direction (0 = increment, 1 = decrement); without it the offset increments.
//
// state | meaning
// IDLE  | parked, waiting for enable; row/frame/offset retained
// FETCH | read request to the frame buffer for the current row
// WAIT  | read data arrives; rotated word latched at the end of this cycle
// SHOW  | rotated row presented for ROW_HOLD cycles
module scroll_reader #(
  parameter int unsigned ROW_HOLD        = 16,
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
`ifdef SCROLL_DIR_EN
  input  logic        dir,
`endif
  output logic [3:0]  addrb,
  output logic        enb,
  input  logic [15:0] data_out,
  output logic [3:0]  row_sel,
  output logic [15:0] row_data,
  output logic        row_valid,
  output logic        frame_start,
  output logic [3:0]  offset
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_SHOW} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(ROW_HOLD - 1);
  localparam logic [7:0] FPS_LAST  = 8'(FRAMES_PER_STEP - 1);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  frame_q, frame_d;
  logic [3:0]  offset_q, offset_d;
  logic [7:0]  hold_q, hold_d;
  logic [3:0]  row_sel_q, row_sel_d;
  logic [15:0] row_data_q, row_data_d;
  logic [15:0] rotated;
  logic        step_down;

`ifdef SCROLL_DIR_EN
  assign step_down = dir;
`else
  assign step_down = 1'b0;
`endif

  // Left rotate of the incoming word; a shift by 16 yields zero so offset 0 is safe.
  always_comb begin
    rotated = (data_out << offset_q) | (data_out >> (5'd16 - {1'b0, offset_q}));
  end

  // State and datapath registers; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      frame_q    <= '0;
      offset_q   <= '0;
      hold_q     <= '0;
      row_sel_q  <= '0;
      row_data_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      frame_q    <= frame_d;
      offset_q   <= offset_d;
      hold_q     <= hold_d;
      row_sel_q  <= row_sel_d;
      row_data_q <= row_data_d;
    end
  end

  // Next-state logic; the hold timer is a down-counter ending at zero.
  // The offset is latched into row_data only at the end of WAIT, so a new
  // offset cannot leak into a frame already in progress.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    frame_d    = frame_q;
    offset_d   = offset_q;
    hold_d     = hold_q;
    row_sel_d  = row_sel_q;
    row_data_d = row_data_q;
    enb        = 1'b0;
    row_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        enb     = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        row_data_d = rotated;
        row_sel_d  = row_q;
        hold_d     = HOLD_LAST;
        state_d    = S_SHOW;
      end
      S_SHOW: begin
        row_valid = 1'b1;
        if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          row_d = row_q + 4'd1;
          if (row_q == 4'd15) begin
            if (frame_q == FPS_LAST) begin
              frame_d  = '0;
              offset_d = step_down ? (offset_q - 4'd1) : (offset_q + 4'd1);
            end else begin
              frame_d = frame_q + 8'd1;
            end
          end
          state_d = enable ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign addrb       = row_q;
  assign row_sel     = row_sel_q;
  assign row_data    = row_data_q;
  assign offset      = offset_q;
  assign frame_start = (state_q == S_SHOW) && (row_q == 4'd0) && (hold_q == HOLD_LAST);

endmodule

// File: tb/tb_scroll_reader.sv
// Randomized scoreboard bench for scroll_reader. Expected displays are
// generated from a plain arithmetic model (display n -> row n%16, frame n/16,
// offset from completed scroll steps) and popped by an independent monitor.
module tb_scroll_reader;

  localparam int RH  = 3;
  localparam int FPS = 2;

  typedef struct packed {
    logic [3:0]  row;
    logic [15:0] data;
    logic [3:0]  off;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
`ifdef SCROLL_DIR_EN
  logic        dir;
`endif
  logic [3:0]  addrb;
  logic        enb;
  logic [15:0] data_out;
  logic [3:0]  row_sel;
  logic [15:0] row_data;
  logic        row_valid;
  logic        frame_start;
  logic [3:0]  offset;

  logic [15:0] mem [16];
  exp_t        q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          shown  = 0;

  int  hold_cnt;
  int  since_enb;
  bit  prev_v, prev_en, have_last, enb_chk_pending;
  logic enb_chk_val;

  scroll_reader #(.ROW_HOLD(RH), .FRAMES_PER_STEP(FPS)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
`ifdef SCROLL_DIR_EN
    .dir         (dir),
`endif
    .addrb       (addrb),
    .enb         (enb),
    .data_out    (data_out),
    .row_sel     (row_sel),
    .row_data    (row_data),
    .row_valid   (row_valid),
    .frame_start (frame_start),
    .offset      (offset)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame buffer: data one cycle after enb.
  always @(posedge clk) if (enb) data_out <= mem[addrb];

  function automatic logic [15:0] rotl16(logic [15:0] w, int o);
    logic [31:0] t;
    t = {w, w} << o;
    return t[31:16];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within budget at %0t", name, $time);
  endtask

  task automatic set_mem_onehot();
    for (int r = 0; r < 16; r++) mem[r] = 16'h0001 << r;
  endtask

  task automatic set_mem_mixed();
    for (int r = 0; r < 16; r++) mem[r] = 16'($urandom);
    mem[0] = 16'h8001;
    mem[1] = 16'h0001;
    mem[2] = 16'hAAAA;
  endtask

  // Reference model: the displayed sequence does not depend on enable timing.
  task automatic push_segment(int n, bit d);
    exp_t e;
    int steps, off;
    q.delete();
    for (int k = 0; k < n; k++) begin
      steps  = (k / 16) / FPS;
      off    = d ? (16 - steps % 16) % 16 : steps % 16;
      e.row  = 4'(k % 16);
      e.off  = 4'(off);
      e.data = rotl16(mem[k % 16], off);
      q.push_back(e);
    end
    shown = 0;
  endtask

  task automatic do_reset_checks();
    reset = 1'b1;
    #1;
    chk("rst_row_valid", row_valid, 0);
    chk("rst_enb", enb, 0);
    chk("rst_offset", offset, 0);
    chk("rst_row_data", row_data, 0);
    chk("rst_row_sel", row_sel, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_addrb", addrb, 0);
  endtask

  task automatic run_random(int target, int budget, string name);
    int n = 0;
    while (shown < target && n < budget) begin
      @(posedge clk); #2;
      enable = ($urandom_range(0, 9) < 8);
      n++;
    end
    if (shown < target) fail(name);
  endtask

  // Monitor: pops one expected display at each row_valid rise and checks timing.
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 0; prev_en = 0; have_last = 0; enb_chk_pending = 0;
      hold_cnt = 0; since_enb = -1;
    end else begin
      if (enb_chk_pending) begin
        chk("enb_after_row", enb, enb_chk_val);
        enb_chk_pending = 0;
      end
      if (enb) begin
        chk("enb_needs_enable", prev_en, 1);
        if (q.size() == 0) fail("fetch_queue_empty");
        else chk("fetch_addr", addrb, q[0].row);
        since_enb = 0;
      end else if (since_enb >= 0) begin
        since_enb++;
      end
      if (row_valid && !prev_v) begin
        chk("fetch_to_show", since_enb, 2);
        since_enb = -1;
        if (q.size() == 0) begin
          fail("show_queue_empty");
        end else begin
          cur = q.pop_front();
          chk("row_sel", row_sel, cur.row);
          chk("row_data", row_data, cur.data);
          chk("offset", offset, cur.off);
          chk("frame_start", frame_start, cur.row == 4'd0);
        end
        hold_cnt = 1; have_last = 1; shown++;
      end else if (row_valid) begin
        hold_cnt++;
        chk("frame_start_mid", frame_start, 0);
        chk("row_data_show", row_data, cur.data);
      end else begin
        if (prev_v) chk("hold_len", hold_cnt, RH);
        chk("frame_start_idle", frame_start, 0);
        if (have_last) chk("row_data_hold", row_data, cur.data);
        else chk("row_data_after_rst", row_data, 0);
      end
      if (row_valid && hold_cnt == RH) begin
        enb_chk_pending = 1;
        enb_chk_val = enable;
      end
      prev_v  = row_valid;
      prev_en = enable;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    reset  = 1'b0;
    enable = 1'b0;
`ifdef SCROLL_DIR_EN
    dir = 1'b0;
`endif
    #2;
    do_reset_checks();
    set_mem_onehot();
    push_segment(1200, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("idle_no_fetch", enb, 0);

    // Run until the fetch of row 9 with offset 3, then reset during WAIT.
    found = 0; n = 0;
    while (!found && n < 4000) begin
      @(posedge clk); #2;
      enable = ($urandom_range(0, 9) < 8);
      @(negedge clk);
      if (enb && addrb == 4'd9 && offset == 4'd3) found = 1;
      n++;
    end
    if (!found) fail("reach_row9_off3");
    else begin
      @(posedge clk); #2;
      do_reset_checks();
    end
    set_mem_mixed();
    push_segment(1200, 0);
    @(posedge clk); #2 reset = 1'b0;

    // Full offset revolution plus one frame.
    run_random(16 * FPS * 16 + 16, 9000, "offset_wrap_run");

    // Drop enable during row 5, then resume.
    enable = 1'b1;
    found = 0; n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      if (row_valid && row_sel == 4'd5) found = 1;
      n++;
    end
    if (!found) fail("reach_row5");
    else begin
      @(posedge clk); #2 enable = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("paused_row_valid", row_valid, 0);
      chk("paused_row_sel", row_sel, 5);
      chk("paused_enb", enb, 0);
      #1 enable = 1'b1;
      found = 0; n = 0;
      while (!found && n < 6) begin
        @(negedge clk);
        if (enb) found = 1;
        n++;
      end
      if (!found) fail("resume_fetch");
      else chk("resume_addr", addrb, 6);
    end
    run_random(shown + 20, 400, "post_resume_run");

`ifdef SCROLL_DIR_EN
    @(posedge clk); #2;
    do_reset_checks();
    dir = 1'b1;
    set_mem_mixed();
    push_segment(600, 1);
    @(posedge clk); #2 reset = 1'b0;
    run_random(16 * FPS + 17, 1200, "dir_down_run");
`endif

    // Reset at a random point mid-activity.
    n = $urandom_range(20, 120);
    repeat (n) begin
      @(posedge clk); #2;
      enable = ($urandom_range(0, 9) < 8);
    end
    do_reset_checks();
    set_mem_mixed();
    push_segment(600, 0);
    @(posedge clk); #2 reset = 1'b0;
    run_random(40, 600, "final_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scroll_reader.md
SCROLL_READER -- requirements
Module: scroll_reader

Interface
REQ-001 Parameter ROW_HOLD, default 16: cycles row_valid stays high per row; legal 1..255.
REQ-002 Parameter FRAMES_PER_STEP, default 4: full frames shown per scroll step; legal 1..255.
REQ-003 clk  input  1  single clock for all state; rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  run request; sampled only in IDLE and on the last SHOW cycle.
REQ-006 addrb  output  4  frame-buffer read address, which is the row index.
REQ-007 enb  output  1  frame-buffer read enable.
REQ-008 data_out  input  16  frame-buffer read data; valid the cycle after enb=1.
REQ-009 row_sel  output  4  row currently displayed.
REQ-010 row_data  output  16  rotated pixel word for row_sel.
REQ-011 row_valid  output  1  high while row_sel/row_data are valid for display.
REQ-012 frame_start  output  1  one-cycle pulse on the first SHOW cycle of row 0.
REQ-013 offset  output  4  current horizontal scroll offset.

Function
REQ-014 FSM states: IDLE, FETCH, WAIT, SHOW; exactly one state active.
REQ-015 IDLE: enable=1 -> FETCH with row=0; otherwise the block stays in IDLE; enb=0 and row_valid=0.
REQ-016 FETCH (1 cycle): enb=1 and addrb=row; next state is WAIT; enb=0 in every other state.
REQ-017 WAIT (1 cycle): capture data_out into the row register at the clock edge ending WAIT; next state is SHOW.
REQ-018 SHOW: row_valid=1 for exactly ROW_HOLD cycles; row_sel=row; row_data = captured word rotated left by offset, so that bit (i+offset) mod 16 of row_data equals bit i of the word.
REQ-019 Row period is ROW_HOLD+2 cycles; frame period is 16*(ROW_HOLD+2) cycles.
REQ-020 Last SHOW cycle with row<15: row increments; next state is FETCH if enable=1, else IDLE.
REQ-021 Last SHOW cycle with row=15: row wraps to 0 and the frame counter increments; next state is FETCH if enable=1, else IDLE.
REQ-022 When the frame counter reaches FRAMES_PER_STEP it clears to 0 and offset increments mod 16 (15 wraps to 0) in the same cycle.
REQ-023 A new offset takes effect from the next frame's row 0; offset never changes within a frame.
REQ-024 Disable at a row boundary (row=k) retains row, frame counter and offset; re-enable resumes at FETCH of row k.
REQ-025 frame_start=1 only on the first SHOW cycle where row=0.
REQ-026 row_sel and row_data hold their last values outside SHOW; row_valid=0 outside SHOW.

Reset
REQ-027 Reset asserted at any time, including mid-row, forces IDLE within the same cycle without waiting for a clock edge.
REQ-028 Reset values: addrb=0, enb=0, row_sel=0, row_data=0, row_valid=0, frame_start=0, offset=0; row and frame counter are 0.
REQ-029 After reset deasserts, the first FETCH occurs no earlier than the first rising edge with enable=1.

Configuration
REQ-030 Macro SCROLL_DIR_EN.
- Defined: an input port dir (1 bit) is added; dir is sampled at each offset update; dir=0 increments offset, dir=1 decrements offset mod 16 (0 -> 15); rotation stays left by offset.
- Undefined: the dir port is absent and offset always increments.

Verification
REQ-031 Reset, enable=1, ROW_HOLD=2, BRAM rows 0..15 = 16'h0001<<row -> enb pulses at addrb 0,1,2,...; each row's row_valid lasts 2 cycles; row_data equals the stored word; row period is 4 cycles.
REQ-032 FRAMES_PER_STEP=1, row 0 = 16'h8001 -> frame 2 row 0 row_data=16'h0003; frame 3 row 0 row_data=16'h0006; frame_start pulses once per frame, 64 cycles apart.
REQ-033 Run 16 scroll steps -> offset goes 1..15 then 0; row_data for 16'hAAAA alternates between 16'h5555 and 16'hAAAA.
REQ-034 Drop enable during SHOW of row 5 -> row 5 completes its full hold, then IDLE; re-enable -> next enb has addrb=6 and offset is unchanged.
REQ-035 Assert reset during WAIT of row 9 with offset=3 -> row_valid=0 and offset=0 immediately, before the next clock edge; after release, the first fetch is row 0.
REQ-036 With SCROLL_DIR_EN defined, dir=1, offset=0 at a step boundary -> offset becomes 15; 16'h0001 is displayed as 16'h8000.
